// File: rtl/serial_alu_pkg.sv
// Shared encodings for the bit-serial ALU: operation codes and sequencer states.
package serial_alu_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_ADD  = 2'b10,
        OP_ZERO = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/serial_alu_alu1.sv
// One-bit ALU slice: the only datapath logic of the serial ALU.
module serial_alu_alu1
    import serial_alu_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    input  op_e  op,
    output logic res,
    output logic cout
);

    always_comb begin
        res = 1'b0;
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_ADD:  res = a ^ b ^ c;
            default: res = 1'b0;
        endcase
    end

    // Carry is produced for every op; the top gates it to ADD when presenting it.
    assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_alu.sv
// Bit-serial WIDTH-bit ALU sequencer: operands shift LSB-first through one
// 1-bit slice, with the slice carry held in a flop between bits.
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       op_i,
    input  logic             sub_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             zero_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state, next_state;
    logic [WIDTH-1:0] a_sh, b_sh, result_sh;
    logic [CW-1:0]    cnt;
    op_e              op_q;
    logic             sub_q;
    logic             carry_q;
    logic             accept;
    logic             sub_eff;
    logic             slice_res, slice_cout;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state   = state;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                accept      = req_valid_i;
                if (req_valid_i) next_state = BUSY;
            end
            BUSY: begin
                if (cnt == LAST) next_state = DONE;
            end
            DONE: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Subtraction inverts B bit by bit and seeds the carry flop with 1.
    assign sub_eff = (op_q == OP_ADD) & sub_q;

    serial_alu_alu1 alu1 (
        .a    (a_sh[0]),
        .b    (b_sh[0] ^ sub_eff),
        .c    (carry_q),
        .op   (op_q),
        .res  (slice_res),
        .cout (slice_cout)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_sh      <= '0;
            b_sh      <= '0;
            result_sh <= '0;
            cnt       <= '0;
            op_q      <= OP_AND;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
        end else if (accept) begin
            a_sh    <= a_i;
            b_sh    <= b_i;
            op_q    <= op_e'(op_i);
            sub_q   <= sub_i;
            carry_q <= (op_e'(op_i) == OP_ADD) & sub_i;
            cnt     <= '0;
        end else if (state == BUSY) begin
            a_sh      <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh      <= {1'b0, b_sh[WIDTH-1:1]};
            result_sh <= {slice_res, result_sh[WIDTH-1:1]};
            carry_q   <= slice_cout;
            cnt       <= cnt + 1'b1;
        end
    end

    assign result_o = result_sh;
    assign carry_o  = carry_q & (op_q == OP_ADD);
    assign zero_o   = (result_sh == '0);

endmodule
